// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and baud-select codes
// for uart_byte_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } sched_state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping NREQ-1 -> 0; one-hot result, all-zero when nothing is requested.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick
);

  logic          found_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;

  // Walk the requesters in priority order starting at ptr.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(i);
      idx_s = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);
      pick[idx_s] = req[idx_s] & ~found_s;
      found_s     = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_byte_tx between NREQ byte-stream requesters; a grant lasts
// for a whole message and priority rotates after each message ends.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TMO  = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              tmo_flag,
  output logic              send_en,
  output logic [7:0]        data_byte,
  input  logic              tx_done,
  input  logic              uart_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  sched_state_t  state_r, state_s;
  logic [PW-1:0] ptr_r, ptr_s;
  logic [PW-1:0] gidx_r, gidx_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [NREQ-1:0] ack_r, ack_s;
  logic [7:0]    data_r, data_s;
  logic          last_r, last_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          send_r, send_s;
  logic          tmo_r, tmo_s;

  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   pick_idx_s;
  logic [PW-1:0]   ptr_inc_s;
  logic [7:0]      byte_s [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign byte_s[i] = data_in[8*i +: 8];
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s)
  );

  // One-hot pick to index; pick is one-hot so OR-ing indices is exact.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_s[i] ? PW'(i) : '0);
    end
  end

  assign ptr_inc_s = (gidx_r == PW'(NREQ-1)) ? '0 : gidx_r + PW'(1);

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gidx_s  = gidx_r;
    grant_s = grant_r;
    data_s  = data_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    ack_s   = '0;
    send_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          grant_s = pick_s;
          gidx_s  = pick_idx_s;
          data_s  = byte_s[pick_idx_s];
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // A busy transmitter (e.g. stale frame after reset) defers the start.
        if (!uart_state) begin
          send_s  = 1'b1;
          last_s  = last[gidx_r];
          state_s = WAIT;
        end else begin
          state_s = LOAD;
        end
      end
      WAIT: begin
        if (tx_done) begin
          ack_s = grant_r;
          if (last_r) begin
            grant_s = '0;
            ptr_s   = ptr_inc_s;
            state_s = IDLE;
          end else begin
            cnt_s   = '0;
            state_s = HOLD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (req[gidx_r]) begin
          data_s  = byte_s[gidx_r];
          state_s = LOAD;
        end else if (cnt_r == CW'(TMO-1)) begin
          tmo_s   = 1'b1;
          grant_s = '0;
          ptr_s   = ptr_inc_s;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        grant_s = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      gidx_r  <= '0;
      grant_r <= '0;
      data_r  <= 8'h00;
      last_r  <= 1'b0;
      cnt_r   <= '0;
      ack_r   <= '0;
      send_r  <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      grant_r <= grant_s;
      data_r  <= data_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      send_r  <= send_s;
      tmo_r   <= tmo_s;
    end
  end

  assign grant     = grant_r;
  assign ack       = ack_r;
  assign send_en   = send_r;
  assign data_byte = data_r;
  assign tmo_flag  = tmo_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester and transmitter models, with a queue of
// expected (owner, byte) pairs checked on every send_en.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int TMO   = 16;
  localparam int FRAME = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req, last, ack, grant;
  logic [8*NREQ-1:0] data_in;
  logic tmo_flag, send_en, tx_done, uart_state;
  logic [7:0] data_byte;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
    .ack(ack), .grant(grant), .tmo_flag(tmo_flag), .send_en(send_en),
    .data_byte(data_byte), .tx_done(tx_done), .uart_state(uart_state)
  );

  typedef struct { int g; logic [7:0] d; } exp_t;
  typedef struct { int rq; logic [7:0] d; logic lst; int exp_g; logic [7:0] exp_d; } vec_t;

  exp_t exp_q[$];
  vec_t vec [5];
  logic [8:0] rbuf [NREQ][8];
  int rlen [NREQ];
  int rpos [NREQ];
  int ack_cnt [NREQ];
  int n_chk, n_fail, cyc, tx_cnt, send_cnt, tmo_cnt, tmo_cyc, ack0_cyc;
  logic [NREQ-1:0] tmo_grant;
  logic force_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      if (rpos[i] < rlen[i]) begin
        req[i] = 1'b1;
        last[i] = rbuf[i][rpos[i]][8];
        data_in[8*i +: 8] = rbuf[i][rpos[i]][7:0];
      end else begin
        req[i] = 1'b0;
        last[i] = 1'b0;
        data_in[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // One clock: requesters react to ack, transmitter model advances.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (ack[i] && rpos[i] < rlen[i]) rpos[i]++;
    tx_done = 1'b0;
    if (send_en) tx_cnt = FRAME;
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    uart_state = (tx_cnt > 0) | force_busy;
    drive_req();
  endtask

  task automatic add_byte(input int rq, input logic [7:0] d, input logic lst);
    rbuf[rq][rlen[rq]] = {lst, d};
    rlen[rq]++;
  endtask

  task automatic add_exp(input int g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  function automatic bit idle_now();
    bit r;
    r = (exp_q.size() == 0) && (grant == '0) && (tx_cnt == 0);
    for (int i = 0; i < NREQ; i++) r = r && (rpos[i] >= rlen[i]);
    return r;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int k;
    k = 0;
    while (!idle_now() && k < budget) begin
      step();
      k++;
    end
    chk({nm, " done in budget"}, 32'(k < budget), 32'd1);
    step();
    step();
  endtask

  // Output monitor on the falling edge; pops the scoreboard on each send_en.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NREQ; i++)
          if (ack[i]) begin
            ack_cnt[i]++;
            if (i == 0) ack0_cyc = cyc;
          end
        if (tmo_flag) begin
          tmo_cnt++;
          tmo_cyc = cyc;
          tmo_grant = grant;
        end
        if (send_en) begin
          send_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected send: data_byte %0h grant %0b, nothing expected", data_byte, grant);
          end else begin
            e = exp_q.pop_front();
            chk("send grant", 32'(grant), 32'(1 << e.g));
            chk("send data_byte", 32'(data_byte), 32'(e.d));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0 [NREQ];
    int s0, t0, k, nexp;
    n_chk = 0; n_fail = 0; cyc = 0; tx_cnt = 0; send_cnt = 0; tmo_cnt = 0;
    tmo_cyc = 0; ack0_cyc = 0; tmo_grant = '0; force_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rlen[i] = 0; rpos[i] = 0; ack_cnt[i] = 0; end
    req = '0; last = '0; data_in = '0; tx_done = 1'b0; uart_state = 1'b0;

    repeat (3) step();
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset tmo_flag", 32'(tmo_flag), 32'd0);
    chk("reset send_en", 32'(send_en), 32'd0);
    chk("reset data_byte", 32'(data_byte), 32'd0);
    rst_n = 1'b1;
    step();

    // Round robin, all four requesting single-byte messages.
    vec[0] = '{0, 8'h10, 1'b1, 0, 8'h10};
    vec[1] = '{1, 8'h20, 1'b1, 1, 8'h20};
    vec[2] = '{2, 8'h30, 1'b1, 2, 8'h30};
    vec[3] = '{3, 8'h40, 1'b1, 3, 8'h40};
    vec[4] = '{0, 8'h50, 1'b1, 0, 8'h50};
    for (int i = 0; i < NREQ; i++) a0[i] = ack_cnt[i];
    for (int v = 0; v < 5; v++) begin
      add_byte(vec[v].rq, vec[v].d, vec[v].lst);
      add_exp(vec[v].exp_g, vec[v].exp_d);
    end
    wait_idle("rr", 400);
    for (int i = 0; i < NREQ; i++) begin
      nexp = 0;
      for (int v = 0; v < 5; v++) if (vec[v].rq == i) nexp++;
      chk("rr ack count", 32'(ack_cnt[i] - a0[i]), 32'(nexp));
    end

    // Single requester, three-byte message.
    a0[0] = ack_cnt[0];
    add_byte(0, 8'h41, 1'b0); add_byte(0, 8'h42, 1'b0); add_byte(0, 8'h43, 1'b1);
    add_exp(0, 8'h41); add_exp(0, 8'h42); add_exp(0, 8'h43);
    wait_idle("msg3", 400);
    chk("msg3 ack0 count", 32'(ack_cnt[0] - a0[0]), 32'd3);
    chk("msg3 grant released", 32'(grant), 32'd0);

    // ptr is now 1: requester 2 beats requester 0.
    add_byte(0, 8'h60, 1'b1); add_byte(2, 8'h62, 1'b1);
    add_exp(2, 8'h62); add_exp(0, 8'h60);
    wait_idle("ptr", 400);

    // Requester 2 arrives while requester 1 is mid-message.
    add_byte(1, 8'hA1, 1'b0); add_byte(1, 8'hA2, 1'b0); add_byte(1, 8'hA3, 1'b1);
    add_exp(1, 8'hA1); add_exp(1, 8'hA2); add_exp(1, 8'hA3); add_exp(2, 8'hB1);
    s0 = send_cnt; k = 0;
    while (send_cnt == s0 && k < 50) begin step(); k++; end
    chk("hold first send seen", 32'(k < 50), 32'd1);
    add_byte(2, 8'hB1, 1'b1);
    wait_idle("hold", 400);

    // Timeout: requester 0 abandons its message; requester 1 waits.
    t0 = tmo_cnt;
    add_byte(0, 8'h55, 1'b0); add_byte(1, 8'h66, 1'b1);
    add_exp(0, 8'h55); add_exp(1, 8'h66);
    wait_idle("tmo", 400);
    chk("tmo pulse count", 32'(tmo_cnt - t0), 32'd1);
    chk("tmo delay after hold", 32'(tmo_cyc - ack0_cyc), 32'(TMO));
    chk("tmo grant cleared", 32'(tmo_grant), 32'd0);

    // Transmitter busy while in LOAD.
    force_busy = 1'b1;
    add_byte(2, 8'h77, 1'b1);
    add_exp(2, 8'h77);
    s0 = send_cnt; k = 0;
    while (grant == '0 && k < 20) begin step(); k++; end
    chk("busy grant seen", 32'(grant), 32'b0100);
    repeat (10) step();
    chk("busy no send", 32'(send_cnt - s0), 32'd0);
    force_busy = 1'b0;
    wait_idle("busy", 400);
    chk("busy one send", 32'(send_cnt - s0), 32'd1);

    // Asynchronous reset in WAIT.
    add_byte(1, 8'h88, 1'b1);
    add_exp(1, 8'h88);
    s0 = send_cnt; k = 0;
    while (send_cnt == s0 && k < 50) begin step(); k++; end
    step();
    chk("pre-reset grant", 32'(grant), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("wait rst grant", 32'(grant), 32'd0);
    chk("wait rst ack", 32'(ack), 32'd0);
    chk("wait rst tmo_flag", 32'(tmo_flag), 32'd0);
    chk("wait rst send_en", 32'(send_en), 32'd0);
    chk("wait rst data_byte", 32'(data_byte), 32'd0);
    for (int i = 0; i < NREQ; i++) begin rlen[i] = 0; rpos[i] = 0; end
    tx_cnt = 0;
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NREQ; i++) a0[i] = ack_cnt[i];
    tx_done = 1'b1;
    repeat (3) step();
    k = 0;
    for (int i = 0; i < NREQ; i++) k += ack_cnt[i] - a0[i];
    chk("stray tx_done ack", 32'(k), 32'd0);
    add_byte(2, 8'hC2, 1'b1); add_byte(3, 8'hC3, 1'b1);
    add_exp(2, 8'hC2); add_exp(3, 8'hC3);
    wait_idle("post-reset rr", 400);
    chk("post-reset ack3", 32'(ack_cnt[3] - a0[3]), 32'd1);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
